// File: rtl/spi_accel_responder_pkg.sv
// Shared definitions for the SPI accelerometer responder: FSM encodings,
// command opcodes, register addresses, request/sample structs and a helper
// for the sign-extended high byte of a 12-bit sample.
package spi_accel_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_REVID     = 6'h03;
  localparam logic [5:0] ADDR_XDATA     = 6'h08;
  localparam logic [5:0] ADDR_YDATA     = 6'h09;
  localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
  localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
  localparam logic [5:0] ADDR_STORE_LO  = 6'h1F;
  localparam logic [5:0] ADDR_STORE_HI  = 6'h2E;

  localparam logic [7:0] DEVID_AD  = 8'hAD;
  localparam logic [7:0] DEVID_MST = 8'h1D;
  localparam logic [7:0] REVID     = 8'h01;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
  } sample_t;

  typedef struct packed {
    logic       en;
    logic [5:0] addr;
    logic [7:0] data;
  } wr_req_t;

  // High byte of a 12-bit two's-complement sample: four copies of the sign
  // bit followed by bits [11:8].
  function automatic logic [7:0] hi_byte(input logic [11:0] s);
    return {{4{s[11]}}, s[11:8]};
  endfunction

endpackage

// File: rtl/spi_accel_regfile.sv
// Register map, sample shadow/live registers and read mux.
// Ports:
//   clk, rst          - system clock, async active-high reset
//   sample_load       - strobe capturing sample_in into the shadow
//   sample_in         - x/y/z 12-bit signed samples
//   busy              - SPI transaction in progress (freezes live samples)
//   wr                - write request (en/addr/data); only storage accepts it
//   rd_addr, rd_data  - combinational read port
module spi_accel_regfile
  import spi_accel_responder_pkg::*;
#(
  parameter logic [7:0] PARTID = 8'hF2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_load,
  input  sample_t    sample_in,
  input  logic       busy,
  input  wr_req_t    wr,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);

  sample_t    shadow;
  sample_t    live;
  logic [7:0] storage [ADDR_STORE_LO:ADDR_STORE_HI];

  // The live copy only moves while idle so a burst read sees one coherent
  // sample. A load landing on an idle cycle bypasses the shadow so it is
  // visible on the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      live   <= '0;
    end else begin
      if (sample_load) shadow <= sample_in;
      if (!busy)       live   <= sample_load ? sample_in : shadow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      storage <= '{default: '0};
    end else if (wr.en && wr.addr >= ADDR_STORE_LO && wr.addr <= ADDR_STORE_HI) begin
      storage[wr.addr] <= wr.data;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_DEVID_AD:  rd_data = DEVID_AD;
      ADDR_DEVID_MST: rd_data = DEVID_MST;
      ADDR_PARTID:    rd_data = PARTID;
      ADDR_REVID:     rd_data = REVID;
      ADDR_XDATA:     rd_data = live.x[11:4];
      ADDR_YDATA:     rd_data = live.y[11:4];
      ADDR_ZDATA:     rd_data = live.z[11:4];
      ADDR_XDATA_L:   rd_data = live.x[7:0];
      ADDR_XDATA_H:   rd_data = hi_byte(live.x);
      ADDR_YDATA_L:   rd_data = live.y[7:0];
      ADDR_YDATA_H:   rd_data = hi_byte(live.y);
      ADDR_ZDATA_L:   rd_data = live.z[7:0];
      ADDR_ZDATA_H:   rd_data = hi_byte(live.z);
      default: begin
        if (rd_addr >= ADDR_STORE_LO && rd_addr <= ADDR_STORE_HI)
          rd_data = storage[rd_addr];
      end
    endcase
  end

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave exposing an accelerometer-style register map.
// Ports:
//   clk, rst                 - system clock, async active-high reset
//   spi_sclk/ncs/mosi        - SPI inputs (asynchronous to clk)
//   spi_miso, spi_miso_oe    - serial read data and its output enable
//   sample_load, sample_x/y/z- new acceleration sample strobe and data
//   reg_wr, reg_wr_addr/data - one-cycle strobe for every written byte
//   busy                     - transaction in progress
module spi_accel_responder
  import spi_accel_responder_pkg::*;
#(
  parameter int         CLK_OVERSAMPLE = 8,
  parameter logic [7:0] PARTID         = 8'hF2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_ncs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic        sample_load,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  output logic        reg_wr,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy
);

  // CLK_OVERSAMPLE is informational: the edge detectors need roughly
  // 3 clk per sclk phase, so ratios well below 8 are outside the design point.
  if (CLK_OVERSAMPLE < 6) begin : g_low_oversample
  end

  logic [1:0] sclk_s, ncs_s, mosi_s;
  logic       sclk_q, ncs_q;
  logic       sclk_rise, sclk_fall, ncs_fall;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] rx_byte;
  logic [7:0] tx_sr;
  logic [5:0] ptr;
  logic       is_rd;
  logic       load_pend;
  logic       byte_done;
  logic       miso_q;
  wr_req_t    wr_q;
  logic [7:0] rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s <= 2'b00;
      ncs_s  <= 2'b11;
      mosi_s <= 2'b00;
      sclk_q <= 1'b0;
      ncs_q  <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[0], spi_sclk};
      ncs_s  <= {ncs_s[0], spi_ncs};
      mosi_s <= {mosi_s[0], spi_mosi};
      sclk_q <= sclk_s[1];
      ncs_q  <= ncs_s[1];
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_q;
  assign sclk_fall = ~sclk_s[1] & sclk_q;
  assign ncs_fall  = ~ncs_s[1] & ncs_q;
  assign rx_byte   = {rx_sr, mosi_s[1]};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state_q != ST_IDLE) && !ncs_s[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ncs_s[1]) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ncs_fall) state_d = ST_CMD;
        ST_CMD:  if (byte_done)
                   state_d = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: if (byte_done) state_d = ST_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'd0;
      tx_sr     <= 8'd0;
      ptr       <= 6'd0;
      is_rd     <= 1'b0;
      load_pend <= 1'b0;
      miso_q    <= 1'b0;
      wr_q      <= '0;
    end else begin
      wr_q.en <= 1'b0;
      if (ncs_s[1]) begin
        // Deselect drops any partial byte and parks MISO low.
        bit_cnt   <= 3'd0;
        load_pend <= 1'b0;
        miso_q    <= 1'b0;
      end else begin
        if (sclk_rise && state_q != ST_IDLE) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state_q)
            ST_CMD:  is_rd <= (rx_byte == CMD_READ);
            ST_ADDR: begin
              ptr       <= rx_byte[5:0];
              load_pend <= is_rd;
            end
            ST_DATA: begin
              if (is_rd) begin
                load_pend <= 1'b1;
              end else begin
                wr_q <= '{en: 1'b1, addr: ptr, data: rx_byte};
                ptr  <= ptr + 6'd1;
              end
            end
            default: ;
          endcase
        end
        // Read data advances on falling edges only; the first fall after a
        // completed byte fetches the next register.
        if (sclk_fall && state_q == ST_DATA && is_rd) begin
          if (load_pend) begin
            miso_q    <= rd_data[7];
            tx_sr     <= {rd_data[6:0], 1'b0};
            ptr       <= ptr + 6'd1;
            load_pend <= 1'b0;
          end else begin
            miso_q <= tx_sr[7];
            tx_sr  <= {tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~ncs_s[1];
  assign busy        = (state_q != ST_IDLE);
  assign reg_wr      = wr_q.en;
  assign reg_wr_addr = wr_q.addr;
  assign reg_wr_data = wr_q.data;

  spi_accel_regfile #(.PARTID(PARTID)) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .sample_load (sample_load),
    .sample_in   ('{x: sample_x, y: sample_y, z: sample_z}),
    .busy        (busy),
    .wr          (wr_q),
    .rd_addr     (ptr),
    .rd_data     (rd_data)
  );

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench: table of SPI transactions plus hand sequences for
// sample coherency, aborted transfers and reset mid-read.
module tb_spi_accel_responder;

  localparam int HALF = 8;  // clk cycles per sclk phase

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0, spi_ncs = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic        sample_load = 1'b0;
  logic [11:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic        reg_wr;
  logic [5:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [5:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  spi_accel_responder dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_ncs(spi_ncs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .sample_load(sample_load), .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= reg_wr_addr;
      last_wd <= reg_wr_data;
    end
  end

  // Bytes are packed first-byte-in-[31:24]; unused trailing bytes are 0.
  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [3:0]  n;
    logic [31:0] tx;
    logic [31:0] exp;
    logic [3:0]  wrs;
    logic [5:0]  wa;
    logic [7:0]  wd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      clks(HALF);
      rx[7-i] = spi_miso;
      spi_sclk = 1'b1;
      clks(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_start();
    spi_ncs = 1'b0;
    clks(HALF);
  endtask

  task automatic spi_end();
    clks(4);
    spi_ncs = 1'b1;
    clks(HALF);
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] addr, input int n,
                          input logic [31:0] tx, output logic [15:0] rx_hdr,
                          output logic [31:0] rx);
    logic [7:0] b;
    rx = '0;
    spi_start();
    spi_bits(cmd, 8, b);  rx_hdr[15:8] = b;
    spi_bits(addr, 8, b); rx_hdr[7:0] = b;
    for (int i = 0; i < n; i++) begin
      spi_bits(tx[31-8*i -: 8], 8, b);
      rx[31-8*i -: 8] = b;
    end
    spi_end();
  endtask

  task automatic read_n(input logic [5:0] a, input int n, output logic [31:0] rx);
    logic [15:0] hdr;
    spi_xfer(8'h0B, {2'b00, a}, n, 32'h0, hdr, rx);
  endtask

  // Six-byte burst from 0x0E, returned as {first 4 bytes, last 2 bytes}.
  task automatic burst6(input bit mid_load, output logic [47:0] rx);
    logic [7:0] b;
    rx = '0;
    spi_start();
    spi_bits(8'h0B, 8, b);
    spi_bits(8'h0E, 8, b);
    for (int i = 0; i < 6; i++) begin
      if (mid_load && i == 2) begin
        sample_x = 12'h7FF; sample_y = 12'hABC; sample_z = 12'h001;
        sample_load = 1'b1;
        clks(1);
        sample_load = 1'b0;
      end
      spi_bits(8'h00, 8, b);
      rx[47-8*i -: 8] = b;
    end
    spi_end();
  endtask

  initial begin
    logic [15:0] hdr;
    logic [31:0] rx;
    logic [47:0] rx6;
    logic [7:0]  b;
    int          w0;
    bit          seen;

    vecs[0]  = '{8'h0B, 8'h00, 4'd4, 32'h0, 32'hAD1DF201, 4'd0, 6'h00, 8'h00};
    vecs[1]  = '{8'h0A, 8'h2C, 4'd1, 32'h5A000000, 32'h0, 4'd1, 6'h2C, 8'h5A};
    vecs[2]  = '{8'h0B, 8'h2C, 4'd1, 32'h0, 32'h5A000000, 4'd0, 6'h00, 8'h00};
    vecs[3]  = '{8'h55, 8'hA5, 4'd1, 32'h3C000000, 32'h0, 4'd0, 6'h00, 8'h00};
    vecs[4]  = '{8'h0B, 8'h3F, 4'd2, 32'h0, 32'h00AD0000, 4'd0, 6'h00, 8'h00};
    vecs[5]  = '{8'h0A, 8'h2E, 4'd2, 32'h11220000, 32'h0, 4'd2, 6'h2F, 8'h22};
    vecs[6]  = '{8'h0B, 8'h2D, 4'd3, 32'h0, 32'h00110000, 4'd0, 6'h00, 8'h00};
    vecs[7]  = '{8'h0A, 8'h01, 4'd1, 32'h77000000, 32'h0, 4'd1, 6'h01, 8'h77};
    vecs[8]  = '{8'h0B, 8'h00, 4'd2, 32'h0, 32'hAD1D0000, 4'd0, 6'h00, 8'h00};
    vecs[9]  = '{8'h0A, 8'h1F, 4'd1, 32'hC3000000, 32'h0, 4'd1, 6'h1F, 8'hC3};
    vecs[10] = '{8'h0B, 8'h1E, 4'd2, 32'h0, 32'h00C30000, 4'd0, 6'h00, 8'h00};
    vecs[11] = '{8'h0B, 8'hC0, 4'd1, 32'h0, 32'hAD000000, 4'd0, 6'h00, 8'h00};

    // Reset state
    clks(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_wr", {17'd0, reg_wr, reg_wr_addr, reg_wr_data}, 32'd0);
    rst = 1'b0;
    clks(4);

    // Select asserts oe and busy
    spi_start();
    check("sel_oe_busy", {30'd0, spi_miso_oe, busy}, 32'd3);
    spi_end();
    check("desel_oe_busy", {30'd0, spi_miso_oe, busy}, 32'd0);

    for (int v = 0; v < 12; v++) begin
      w0 = wr_cnt;
      spi_xfer(vecs[v].cmd, vecs[v].addr, int'(vecs[v].n), vecs[v].tx, hdr, rx);
      check($sformatf("v%0d_hdr_miso", v), {16'd0, hdr}, 32'd0);
      check($sformatf("v%0d_data", v), rx, vecs[v].exp);
      check($sformatf("v%0d_wr_cnt", v), wr_cnt - w0, {28'd0, vecs[v].wrs});
      if (vecs[v].wrs != 0)
        check($sformatf("v%0d_wr_last", v), {18'd0, last_wa, last_wd}, {18'd0, vecs[v].wa, vecs[v].wd});
    end

    // Sample capture and formatting
    sample_x = 12'hF83; sample_y = 12'h123; sample_z = 12'h800;
    sample_load = 1'b1; clks(1); sample_load = 1'b0;
    clks(2);
    read_n(6'h0E, 2, rx);
    check("x_lo_hi", rx, 32'h83FF0000);
    read_n(6'h08, 3, rx);
    check("xyz_msb", rx, 32'hF8128000);

    // Burst coherency with a load mid-transfer
    burst6(1'b1, rx6);
    check("burst_old", rx6[47:16], 32'h83FF2301);
    check("burst_old_z", {16'd0, rx6[15:0]}, 32'h000000F8);
    burst6(1'b0, rx6);
    check("burst_new", rx6[47:16], 32'hFF07BCFA);
    check("burst_new_z", {16'd0, rx6[15:0]}, 32'h00000100);

    // Load in the first idle cycle after a transaction
    spi_start();
    spi_bits(8'h0B, 8, b);
    spi_bits(8'h00, 8, b);
    spi_bits(8'h00, 8, b);
    clks(4);
    spi_ncs = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check("busy_drop", {31'd0, seen}, 32'd1);
    sample_x = 12'h5A0;
    sample_load = 1'b1; clks(1); sample_load = 1'b0;
    clks(HALF);
    read_n(6'h08, 1, rx);
    check("load_at_idle", rx, 32'h5A000000);

    // Write aborted after 4 data bits
    w0 = wr_cnt;
    spi_start();
    spi_bits(8'h0A, 8, b);
    spi_bits(8'h20, 8, b);
    spi_bits(8'hFF, 4, b);
    spi_end();
    check("abort_no_wr", wr_cnt - w0, 32'd0);
    read_n(6'h20, 1, rx);
    check("abort_store", rx, 32'h0);

    // Reset mid-read
    w0 = wr_cnt;
    spi_start();
    spi_bits(8'h0B, 8, b);
    spi_bits(8'h00, 8, b);
    spi_bits(8'h00, 3, b);
    rst = 1'b1;
    clks(2);
    check("midrst_state", {29'd0, busy, spi_miso, spi_miso_oe}, 32'd0);
    spi_ncs = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(4);
    check("midrst_no_wr", wr_cnt - w0, 32'd0);
    read_n(6'h00, 2, rx);
    check("post_rst_read", rx, 32'hAD1D0000);
    read_n(6'h2E, 1, rx);
    check("post_rst_store", rx, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_accel_responder.md
SPI_ACCEL_RESPONDER -- requirements
Module: spi_accel_responder

Interface
REQ-001 Parameter CLK_OVERSAMPLE, default 8, minimum clk/spi_sclk frequency ratio supported; documentation only, not checked in RTL.
REQ-002 Parameter PARTID, default 8'hF2, value returned at register 0x02.
REQ-003 Ports: clk input 1, system clock; the block SHALL use one clock only.
REQ-004 Ports: rst input 1, reset; it SHALL be asynchronous and active-high.
REQ-005 Ports: spi_sclk input 1, SPI clock (mode 0, idle low); spi_ncs input 1, active-low chip select; spi_mosi input 1, serial data from the master.
REQ-006 Ports: spi_miso output 1, serial data to the master; spi_miso_oe output 1, high while spi_ncs is low (synchronised).
REQ-007 Ports: sample_load input 1, single-cycle strobe; sample_x, sample_y, sample_z input 12 each, signed acceleration samples.
REQ-008 Ports: reg_wr output 1, single-cycle write strobe; reg_wr_addr output 6; reg_wr_data output 8; busy output 1, high for the whole transaction.

Function
REQ-009 spi_sclk, spi_ncs and spi_mosi SHALL each pass through 2 synchroniser flops; edges SHALL be detected on the synchronised signals.
REQ-010 FSM states: IDLE, CMD, ADDR, DATA, IGNORE; a 3-bit bit counter SHALL count sclk rising edges within each byte.
REQ-011 IDLE->CMD on a synchronised ncs falling edge; any state->IDLE within 1 clk of a synchronised ncs rising edge, discarding any partial byte.
REQ-012 MOSI SHALL be sampled on the sclk rising edge, MSB first; MISO SHALL change only on sclk falling edges.
REQ-013 CMD: after 8 bits, 0x0A->ADDR (write), 0x0B->ADDR (read), any other value->IGNORE.
REQ-014 IGNORE SHALL hold spi_miso at 0 and produce no writes until ncs deasserts.
REQ-015 ADDR: after 8 bits, the low 6 bits SHALL be latched as the pointer and the state SHALL go to DATA; bits [7:6] SHALL be ignored.
REQ-016 Read DATA: on the falling edge after the 8th address bit (or the 8th bit of the previous data byte), the byte at the pointer SHALL load into the shift register with its MSB on spi_miso; the pointer SHALL then increment.
REQ-017 Write DATA: after each 8th bit, reg_wr SHALL pulse for 1 clk with the pointer and the byte; writable registers update; the pointer SHALL then increment.
REQ-018 The pointer SHALL wrap from 0x3F to 0x00.
REQ-019 Register map: 0x00=0xAD, 0x01=0x1D, 0x02=PARTID, 0x03=0x01 (all read-only).
REQ-020 Register map: 0x08/0x09/0x0A=x/y/z[11:4]; 0x0E..0x13=x,y,z as low byte [7:0], then high byte {4 sign bits, [11:8]} (all read-only).
REQ-021 Register map: 0x1F..0x2E SHALL be read/write storage.
REQ-022 All other addresses SHALL read 0x00; writes to read-only or unmapped addresses SHALL pulse reg_wr but SHALL NOT change state.
REQ-023 sample_load SHALL capture into a shadow register at any time; the shadow SHALL copy to the live sample registers only when busy is low, so a burst read is coherent.
REQ-024 If sample_load coincides with a busy falling edge, the new sample SHALL be visible on the next cycle.
REQ-025 spi_miso SHALL be 0 whenever it is not shifting read data.

Reset
REQ-026 On rst: FSM=IDLE, counter=0, pointer=0, spi_miso=0, spi_miso_oe=0, reg_wr=0, reg_wr_addr=0, reg_wr_data=0, busy=0, sample and storage registers=0.
REQ-027 The synchroniser flops SHALL reset to sclk=0, ncs=1, mosi=0.
REQ-028 Reset asserted mid-transaction SHALL abort it; after release, the block SHALL wait for a fresh ncs falling edge.

Structure
REQ-029 A shared package SHALL hold the FSM state encodings, the command opcodes (0x0A, 0x0B) and the register address constants.
REQ-030 One sub-module, spi_accel_regfile, SHALL hold the register map, the shadow/live sample logic and the read mux; the top holds the synchronisers, FSM and shift registers.

Verification
REQ-031 Bench: read 0x0B, 0x00 followed by 4 bytes -> MISO returns 0xAD, 0x1D, 0xF2, 0x01.
REQ-032 Bench: write 0x0A, 0x2C, 0x5A, then read 0x2C -> reg_wr pulses with addr 0x2C, data 0x5A; the read returns 0x5A.
REQ-033 Bench: sample_load with x=12'hF83, then read from 0x0E for 2 bytes -> 0x83, 0xFF; read 0x08 -> 0xF8.
REQ-034 Bench: sample_load pulsed mid-burst while reading 0x0E..0x13 -> the whole burst returns the old values; a following read returns the new values.
REQ-035 Bench: command 0x55 followed by 2 bytes -> MISO stays 0 and no reg_wr; read from 0x3F for 2 bytes -> 0x00, 0xAD (wrap).
REQ-036 Bench: ncs raised after 4 data bits, and rst asserted mid-read -> no reg_wr; the next transaction is correct.
